rv_mem_sys: RTL and testbench



---
 rtl/rv_mem_pkg.sv | 29 ++
 rtl/rv_mem_sys_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 142 ++++++++++++++
 rtl/rv_mem_sys.sv | 85 ++++++++
 tb/tb_rv_mem_sys.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the rv32i memory/MMIO subsystem: MMIO address map,
// UART_STATUS bit positions and the UART transmitter state encoding.
package rv_mem_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] UART_DATA   = MMIO_BASE + 32'h0;
  localparam logic [31:0] UART_STATUS = MMIO_BASE + 32'h4;
  localparam logic [31:0] HALT        = MMIO_BASE + 32'h8;

  // UART_STATUS layout
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Byte address -> word-aligned address; the core's low two bits are ignored.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_mem_sys_if.sv
// Core memory port bundle.
//   mem_addr  : byte address (bits [1:0] ignored)
//   mem_wdata : write data
//   mem_we    : write strobe, one write per rising edge while high
//   mem_rdata : combinational read data for mem_addr
interface rv_mem_sys_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input  mem_rdata);
  modport slave  (input  mem_addr, input  mem_wdata, input  mem_we, output mem_rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO, TX state machine, baud/bit
// counters and the UART_STATUS word.
//   clk, rst_n   : clock, async active-low reset
//   i_push       : push i_push_data into the FIFO on this edge
//   i_push_data  : byte to transmit
//   o_uart_tx    : serial line, idle high
//   o_status     : UART_STATUS word (full, empty, busy, overflow, count)
module uart_tx_fifo
  import rv_mem_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [7:0]  i_push_data,
  output logic        o_uart_tx,
  output logic [31:0] o_status
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  tx_state_e     r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_line;
  logic          r_uart_tx;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop;
  logic w_baud_done;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok   = i_push && !w_full;
  assign w_baud_done = (r_baud == BAUD_LAST);
  // Pop when idle, or at the last cycle of STOP so frames run back to back.
  assign w_pop       = !w_empty &&
                       ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_done));

  // NOTE: FIFO storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && w_full) r_overflow <= 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM. r_line is the next line level; r_uart_tx delays it one cycle so
  // the start bit appears the cycle after the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_line    <= 1'b1;
      r_uart_tx <= 1'b1;
    end else begin
      r_uart_tx <= r_line;
      if (w_pop) begin
        r_state <= TX_START;
        r_shift <= r_fifo[r_rd_ptr];
        r_baud  <= '0;
        r_line  <= 1'b0;
      end else if (r_state != TX_IDLE) begin
        if (!w_baud_done) begin
          r_baud <= r_baud + BW'(1);
        end else begin
          r_baud <= '0;
          case (r_state)
            TX_START: begin
              r_state   <= TX_DATA;
              r_bit_idx <= '0;
              r_line    <= r_shift[0];
            end
            TX_DATA: begin
              if (r_bit_idx == 3'd7) begin
                r_state <= TX_STOP;
                r_line  <= 1'b1;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= r_shift >> 1;
                r_line    <= r_shift[1];
              end
            end
            default: begin
              // End of STOP with nothing queued.
              r_state <= TX_IDLE;
              r_line  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign o_uart_tx = r_uart_tx;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_status                      = '0;
    o_status[ST_FULL]             = w_full;
    o_status[ST_EMPTY]            = w_empty;
    o_status[ST_BUSY]             = (r_state != TX_IDLE);
    o_status[ST_OVF]              = r_overflow;
    o_status[ST_CNT_LSB +: 8]     = 8'(r_count);
  end

endmodule

// File: rtl/rv_mem_sys.sv
// Memory and MMIO subsystem behind the rv32i core memory port: word RAM,
// buffered UART transmitter and halt/result mailbox.
//   clk, rst_n : clock, async active-low reset
//   mem        : core memory port (slave side), combinational read data
//   uart_tx    : 8N1 serial output, idle high
//   halt       : sticky, set by a write to HALT
//   halt_code  : last value written to HALT
module rv_mem_sys
  import rv_mem_pkg::*;
#(
  parameter int    MEM_WORDS  = 1024,
  parameter string INIT_FILE  = "",
  parameter int    CLK_DIV    = 868,
  parameter int    FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_mem_sys_if.slave  mem,
  output logic         uart_tx,
  output logic         halt,
  output logic [31:0]  halt_code
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   r_ram [MEM_WORDS];
  logic          r_halt;
  logic [31:0]   r_halt_code;

  logic [31:0]   w_word;
  logic          w_in_ram;
  logic [AW-1:0] w_ram_idx;
  logic          w_uart_push;
  logic [31:0]   w_status;

  assign w_word      = word_addr(mem.mem_addr);
  // RAM occupies the first 4*MEM_WORDS bytes; nothing aliases above that.
  assign w_in_ram    = (mem.mem_addr[31:AW+2] == '0);
  assign w_ram_idx   = mem.mem_addr[AW+1:2];
  assign w_uart_push = mem.mem_we && (w_word == UART_DATA);

  always_ff @(posedge clk) begin
    if (mem.mem_we && w_in_ram) r_ram[w_ram_idx] <= mem.mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt      <= 1'b0;
      r_halt_code <= '0;
    end else if (mem.mem_we && (w_word == HALT)) begin
      r_halt      <= 1'b1;
      r_halt_code <= mem.mem_wdata;
    end
  end

  // Combinational read: the core samples this the cycle after it registers mem_addr.
  always_comb begin
    mem.mem_rdata = '0;
    if (w_in_ram) begin
      mem.mem_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_word)
        UART_STATUS: mem.mem_rdata = w_status;
        HALT:        mem.mem_rdata = r_halt_code;
        default:     mem.mem_rdata = '0;
      endcase
    end
  end

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_uart_push),
    .i_push_data (mem.mem_wdata[7:0]),
    .o_uart_tx   (uart_tx),
    .o_status    (w_status)
  );

  assign halt      = r_halt;
  assign halt_code = r_halt_code;

endmodule

// File: tb/tb_rv_mem_sys.sv
// Self-checking bench for rv_mem_sys: directed scenarios followed by random
// bus traffic, all compared against a transaction-level reference model
// (RAM array, byte queue, frame-timing arithmetic, halt mailbox).
module tb_rv_mem_sys;
  import rv_mem_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 256;
  localparam int AW         = $clog2(MEM_WORDS);
  localparam int FRAME      = 10 * CLK_DIV;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_tx;
  logic        halt;
  logic [31:0] halt_code;

  rv_mem_sys_if bus ();

  rv_mem_sys #(
    .MEM_WORDS  (MEM_WORDS),
    .INIT_FILE  (""),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (bus),
    .uart_tx   (uart_tx),
    .halt      (halt),
    .halt_code (halt_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  m_ram   [MEM_WORDS];
  bit           m_valid [MEM_WORDS];
  byte unsigned m_q [$];
  bit           m_idle = 1'b1;
  longint       m_frame_end = 0;
  bit           m_ovf = 1'b0;
  bit           m_halt = 1'b0;
  logic [31:0]  m_code = '0;
  bit           m_sent = 1'b0;
  longint       m_last_pop = 0;
  logic [7:0]   m_last_byte = '0;
  longint       cyc = 0;

  function automatic void m_reset();
    m_q.delete();
    m_idle = 1'b1;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_code = '0;
    m_sent = 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (m_q.size() == FIFO_DEPTH);
    s[1]    = (m_q.size() == 0);
    s[2]    = !m_idle;
    s[3]    = m_ovf;
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (addr < RAM_BYTES) return m_ram[addr[AW+1:2]];
    if (w == UART_STATUS) return m_status();
    if (w == HALT)        return m_code;
    return 32'h0;
  endfunction

  // Line level after the current edge: start bit, 8 data bits LSB first,
  // stop bit, each CLK_DIV cycles, beginning the cycle after the pop edge.
  function automatic logic m_line();
    longint d;
    longint k;
    if (!m_sent) return 1'b1;
    d = cyc - m_last_pop - 1;
    if (d < 0 || d >= FRAME) return 1'b1;
    k = d / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_last_byte[k-1];
    return 1'b1;
  endfunction

  // One bus cycle: drive at negedge, check read data, model the edge, check outputs.
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input string tag);
    bit pop;
    bit push;
    int pre;
    logic [31:0] w;
    @(negedge clk);
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    #1;
    check({tag, "/rdata"}, bus.mem_rdata, m_read(addr));
    @(posedge clk);
    cyc++;
    w    = {addr[31:2], 2'b00};
    pre  = m_q.size();
    pop  = (pre > 0) && (m_idle || cyc == m_frame_end);
    push = we && (w == UART_DATA);
    if (pop) begin
      m_last_byte = m_q.pop_front();
      m_last_pop  = cyc;
      m_frame_end = cyc + FRAME;
      m_idle      = 1'b0;
      m_sent      = 1'b1;
    end else if (!m_idle && cyc == m_frame_end) begin
      m_idle = 1'b1;
    end
    if (push) begin
      if (pre == FIFO_DEPTH) m_ovf = 1'b1;
      else m_q.push_back(wdata[7:0]);
    end
    if (we && addr < RAM_BYTES) begin
      m_ram[addr[AW+1:2]]   = wdata;
      m_valid[addr[AW+1:2]] = 1'b1;
    end
    if (we && w == HALT) begin
      m_halt = 1'b1;
      m_code = wdata;
    end
    #1;
    check({tag, "/uart_tx"}, {31'b0, uart_tx}, {31'b0, m_line()});
    check({tag, "/halt"}, {31'b0, halt}, {31'b0, m_halt});
    check({tag, "/halt_code"}, halt_code, m_code);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, UART_STATUS, 32'h0, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 * FRAME && (!m_idle || m_q.size() != 0); i++)
      step(1'b0, UART_STATUS, 32'h0, tag);
    idle(2, tag);
  endtask

  // Asynchronous reset in the middle of a low clock phase.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = UART_STATUS;
    bus.mem_wdata = '0;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check({tag, "/uart_tx"}, {31'b0, uart_tx}, 32'h1);
    check({tag, "/halt"}, {31'b0, halt}, 32'h0);
    check({tag, "/halt_code"}, halt_code, 32'h0);
    check({tag, "/status"}, bus.mem_rdata, 32'h0000_0002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int idx;
    logic [31:0] a;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    do_reset("reset");

    // RAM basics and range boundaries
    step(1'b1, 32'h0000_0010, 32'h1234_5678, "ram_w");
    step(1'b0, 32'h0000_0010, 32'h0, "ram_r10");
    step(1'b0, 32'h0000_0013, 32'h0, "ram_r13");
    step(1'b0, 32'h0000_2000, 32'h0, "unmapped_r");
    step(1'b1, 32'h0000_0000, 32'h0BAD_F00D, "ram_w0");
    step(1'b1, RAM_BYTES - 4, 32'h7777_AAAA, "ram_wlast");
    step(1'b1, RAM_BYTES, 32'hDEAD_BEEF, "past_ram_w");
    step(1'b0, 32'h0000_0000, 32'h0, "ram_r0");
    step(1'b0, RAM_BYTES - 4, 32'h0, "ram_rlast");
    step(1'b1, 32'h8000_000C, 32'h1111_2222, "mmio_hole_w");
    step(1'b0, 32'h8000_000C, 32'h0, "mmio_hole_r");

    // Single byte 0x41, full frame checked cycle by cycle
    step(1'b1, UART_DATA, 32'h0000_0041, "tx41");
    drain("tx41_frame");

    // Two frames back to back
    step(1'b1, UART_DATA, 32'h0000_0055, "tx55");
    step(1'b1, UART_DATA, 32'h0000_00AA, "txAA");
    drain("b2b");

    // Six pushes while idle: one pops, four buffered, one dropped
    for (int i = 0; i < 6; i++) step(1'b1, UART_DATA, 32'(8'h30 + i), "burst");
    step(1'b0, UART_STATUS, 32'h0, "burst_status");
    drain("burst_frames");

    // Halt mailbox
    step(1'b1, HALT, 32'hCAFE_0001, "halt_w");
    step(1'b0, HALT, 32'h0, "halt_r");
    step(1'b1, HALT, 32'h0000_BEEF, "halt_w2");
    step(1'b0, HALT, 32'h0, "halt_r2");

    // Reset at cycle 10 of a frame; RAM must survive
    step(1'b1, UART_DATA, 32'h0000_00A5, "pre_rst");
    idle(11, "mid_frame");
    do_reset("mid_rst");
    idle(3, "post_rst");
    step(1'b0, 32'h0000_0010, 32'h0, "ram_kept");

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      idx = $urandom_range(0, MEM_WORDS - 1);
      if (r < 35 || (r < 60 && !m_valid[idx])) begin
        a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        step(1'b1, a, $urandom, "rnd_ram_w");
      end else if (r < 60) begin
        a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        step(1'b0, a, $urandom, "rnd_ram_r");
      end else if (r < 70) begin
        step(1'b1, UART_DATA, $urandom, "rnd_uart_w");
      end else if (r < 80) begin
        step(1'b0, UART_STATUS, $urandom, "rnd_status");
      end else if (r < 84) begin
        step(1'b1, HALT, $urandom, "rnd_halt_w");
      end else if (r < 88) begin
        step(1'b0, HALT, $urandom, "rnd_halt_r");
      end else if (r < 94) begin
        case ($urandom_range(0, 4))
          0:       a = RAM_BYTES + 32'(idx * 4);
          1:       a = 32'h8000_000C;
          2:       a = 32'h4000_0000 + 32'(idx * 4);
          3:       a = 32'hFFFF_FFFC;
          default: a = 32'h8000_0010;
        endcase
        step(1'($urandom_range(0, 1)), a, $urandom, "rnd_unmapped");
      end else begin
        step(1'b0, UART_DATA, $urandom, "rnd_uart_r");
      end
    end
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
